// File: rtl/hyperram_lb_arbiter.sv
// hyperram_lb_arbiter: round-robin arbiter that shares one HyperRAM controller
// local-bus register port between two single-word requesters (A and B) and
// expands each granted transaction into the controller's register sequence.
module hyperram_lb_arbiter #(
  parameter int BUSY_SETTLE = 4,
  parameter int TIMEOUT     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic        lb_wr,
  output logic        lb_rd,
  output logic [31:0] lb_addr,
  output logic [31:0] lb_wr_d,
  input  logic [31:0] lb_rd_d,
  input  logic        lb_rd_rdy,
  input  logic        hr_busy,
  output logic        owner,
  output logic        timeout_flag,
  input  logic        clear_timeout
);

  typedef enum logic [2:0] {
    IDLE, SET_ADDR, SET_DATA, CMD, WAIT_BUSY, RD_ISSUE, RD_WAIT, DONE
  } state_t;

  // Counter starts at 0 on the first WAIT_BUSY cycle, so the last settle cycle
  // and the last allowed wait cycle are both "limit - 1".
  localparam logic [15:0] SETTLE_LAST  = 16'(BUSY_SETTLE - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  localparam logic [31:0] REG_ADDR = 32'h0000_0010;
  localparam logic [31:0] REG_DATA = 32'h0000_0014;
  localparam logic [31:0] REG_CMD  = 32'h0000_001c;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;          // 1 = B won the previous grant
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic        tflag_q, tflag_d;

  logic        grant_b;
  logic        tflag_set;
  logic [15:0] cnt_inc;

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  // B wins when it is alone, or when both ask and A won last time.
  assign grant_b = b_req && (!a_req || !last_q);

  // State register and captured transaction context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      cnt_q     <= 16'd0;
      err_q     <= 1'b0;
      a_rdata_q <= 32'd0;
      b_rdata_q <= 32'd0;
      tflag_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      tflag_q   <= tflag_d;
    end
  end

  // Next-state logic: arbitration, sequencing, busy/ready waits and timeout.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    tflag_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          owner_d = grant_b;
          last_d  = grant_b;
          we_d    = grant_b ? b_we    : a_we;
          addr_d  = grant_b ? b_addr  : a_addr;
          wdata_d = grant_b ? b_wdata : a_wdata;
          err_d   = 1'b0;
          state_d = SET_ADDR;
        end
      end
      SET_ADDR: state_d = we_q ? SET_DATA : CMD;
      SET_DATA: state_d = CMD;
      CMD: begin
        cnt_d   = 16'd0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        cnt_d = cnt_inc;
        // Normal exit is checked first so it beats a coincident timeout.
        if (cnt_q >= SETTLE_LAST && !hr_busy) begin
          state_d = we_q ? DONE : RD_ISSUE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d     = 1'b1;
          tflag_set = 1'b1;
          state_d   = DONE;
        end
      end
      RD_ISSUE: begin
        cnt_d   = 16'd0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        cnt_d = cnt_inc;
        if (lb_rd_rdy) begin
          if (owner_q) b_rdata_d = lb_rd_d;
          else         a_rdata_d = lb_rd_d;
          state_d = DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d     = 1'b1;
          tflag_set = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A clear in the same cycle as a timeout leaves the flag low.
    if (clear_timeout)  tflag_d = 1'b0;
    else if (tflag_set) tflag_d = 1'b1;
    else                tflag_d = tflag_q;
  end

  // Local-bus strobes decoded purely from the registered state.
  always_comb begin
    lb_wr   = 1'b0;
    lb_rd   = 1'b0;
    lb_addr = 32'd0;
    lb_wr_d = 32'd0;
    case (state_q)
      SET_ADDR: begin
        lb_wr   = 1'b1;
        lb_addr = REG_ADDR;
        lb_wr_d = addr_q;
      end
      SET_DATA: begin
        lb_wr   = 1'b1;
        lb_addr = REG_DATA;
        lb_wr_d = wdata_q;
      end
      CMD: begin
        lb_wr   = 1'b1;
        lb_addr = REG_CMD;
        lb_wr_d = we_q ? 32'd1 : 32'd4;
      end
      RD_ISSUE: begin
        lb_rd   = 1'b1;
        lb_addr = REG_DATA;
      end
      default: ;
    endcase
  end

  assign a_ack        = (state_q == DONE) && !owner_q;
  assign b_ack        = (state_q == DONE) &&  owner_q;
  assign a_err        = a_ack && err_q;
  assign b_err        = b_ack && err_q;
  assign a_rdata      = a_rdata_q;
  assign b_rdata      = b_rdata_q;
  assign owner        = owner_q;
  assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_hyperram_lb_arbiter.sv
// tb_hyperram_lb_arbiter: table vectors, hand sequences and randomized
// transactions checked against a cycle-count model of the arbiter.
module tb_hyperram_lb_arbiter;

  localparam int BS = 4;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        lb_wr, lb_rd, lb_rd_rdy, hr_busy;
  logic [31:0] lb_addr, lb_wr_d, lb_rd_d;
  logic        owner, timeout_flag, clear_timeout;

  hyperram_lb_arbiter #(.BUSY_SETTLE(BS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wr_d(lb_wr_d),
    .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy), .hr_busy(hr_busy),
    .owner(owner), .timeout_flag(timeout_flag), .clear_timeout(clear_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          busy_n;
    bit          stuck;
    int          rdy_d;
    logic [31:0] rdy_v;
    int          lat;
    bit          err;
    logic [31:0] ra;
    logic [31:0] rb;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Local-bus responder controls.
  int          busy_n = 0;
  bit          busy_stuck = 0;
  int          busy_ctr = 0;
  int          rdy_delay = 1;
  int          rdy_ctr = 0;
  logic [31:0] rdy_val = 32'd0;
  bit          glitch = 0;
  bus_t        bus_log[$];
  bit          bus_dirty = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs 1ns after the edge, then drive responder inputs.
  task automatic step();
    bus_t e;
    @(posedge clk);
    #1;
    if (lb_wr || lb_rd) begin
      e.rd = lb_rd; e.addr = lb_addr; e.data = lb_wr_d;
      bus_log.push_back(e);
      if (lb_wr && lb_rd) bus_dirty = 1;
    end else if (lb_addr !== 32'd0 || lb_wr_d !== 32'd0) begin
      bus_dirty = 1;
    end
    if (lb_wr && lb_addr == 32'h1c) begin
      busy_ctr = busy_n;
      hr_busy  = busy_stuck;
    end else if (busy_ctr > 0) begin
      hr_busy = 1'b1;
      busy_ctr--;
    end else begin
      hr_busy = busy_stuck;
    end
    lb_rd_rdy = 1'b0;
    lb_rd_d   = $urandom;
    if (lb_rd) rdy_ctr = rdy_delay;
    else if (rdy_ctr > 0) begin
      rdy_ctr--;
      if (rdy_ctr == 0) begin
        lb_rd_rdy = 1'b1;
        lb_rd_d   = rdy_val;
      end
    end
    if (glitch && lb_wr && lb_addr == 32'h10) begin
      lb_rd_rdy = 1'b1;
      lb_rd_d   = 32'hBAD0_BAD0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".a_ack"}, a_ack, 0);
    chk({tag, ".b_ack"}, b_ack, 0);
    chk({tag, ".a_err"}, a_err, 0);
    chk({tag, ".b_err"}, b_err, 0);
    chk({tag, ".lb_wr"}, lb_wr, 0);
    chk({tag, ".lb_rd"}, lb_rd, 0);
    chk({tag, ".lb_addr"}, lb_addr, 0);
    chk({tag, ".lb_wr_d"}, lb_wr_d, 0);
    chk({tag, ".a_rdata"}, a_rdata, 0);
    chk({tag, ".b_rdata"}, b_rdata, 0);
    chk({tag, ".owner"}, owner, 0);
    chk({tag, ".timeout_flag"}, timeout_flag, 0);
  endtask

  // Issue one transaction from one port and follow it to its ack (bounded).
  task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output bit err,
                        output bit own, output bit other_ack, output bit got);
    bus_log.delete();
    bus_dirty = 0; busy_ctr = 0; rdy_ctr = 0;
    other_ack = 0; got = 0; err = 0; own = 0; lat = 0;
    if (!port) begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
    else       begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
    while (!got && lat < 300) begin
      step();
      lat++;
      if (port ? a_ack : b_ack) other_ack = 1;
      if (port ? b_ack : a_ack) begin
        got = 1;
        err = port ? b_err : a_err;
        own = owner;
        a_req = 0; b_req = 0;
      end
    end
    a_req = 0; b_req = 0;
    step();
    if (a_ack || b_ack) other_ack = 1;
  endtask

  task automatic check_txn(input string tag, input bit port, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit issued, input int exp_lat, input bit exp_err,
                           input logic [31:0] exp_ra, input logic [31:0] exp_rb,
                           input int lat, input bit err, input bit own,
                           input bit other_ack, input bit got);
    bus_t exp_q[$];
    exp_q.push_back('{1'b0, 32'h10, addr});
    if (we) exp_q.push_back('{1'b0, 32'h14, wdata});
    exp_q.push_back('{1'b0, 32'h1c, we ? 32'd1 : 32'd4});
    if (!we && issued) exp_q.push_back('{1'b1, 32'h14, 32'd0});
    chk({tag, ".ack_seen"}, got, 1);
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".err"}, err, exp_err);
    chk({tag, ".owner"}, own, port);
    chk({tag, ".other_ack"}, other_ack, 0);
    chk({tag, ".a_rdata"}, a_rdata, exp_ra);
    chk({tag, ".b_rdata"}, b_rdata, exp_rb);
    chk({tag, ".bus_len"}, bus_log.size(), exp_q.size());
    chk({tag, ".bus_idle_zero"}, bus_dirty, 0);
    for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++) begin
      chk($sformatf("%s.bus%0d_rd", tag, i), bus_log[i].rd, exp_q[i].rd);
      chk($sformatf("%s.bus%0d_addr", tag, i), bus_log[i].addr, exp_q[i].addr);
      chk($sformatf("%s.bus%0d_data", tag, i), bus_log[i].data, exp_q[i].data);
    end
    chk({tag, ".tflag"}, timeout_flag, exp_err);
    clear_timeout = 1;
    step();
    clear_timeout = 0;
    chk({tag, ".tflag_clr"}, timeout_flag, 0);
  endtask

  // Grant-to-ack cycle count from the phase lengths the block goes through.
  function automatic void ref_model(input bit we, input int bn, input int rd_d,
                                    output int lat, output bit err, output bit issued);
    int k;
    int j;
    int t;
    err = 0; issued = 0;
    t = we ? 4 : 3;              // first WAIT_BUSY cycle after grant
    k = 0;
    while (1) begin
      if (k >= BS - 1 && k >= bn) break;   // settled and not busy
      if (k == TO - 1) begin err = 1; break; end
      k++;
    end
    t = t + k + 1;
    if (we || err) begin
      lat = t;
      return;
    end
    issued = 1;
    t = t + 1;                   // first RD_WAIT cycle
    j = 0;
    while (1) begin
      if (rd_d > 0 && j == rd_d - 1) break;
      if (j == TO - 1) begin err = 1; break; end
      j++;
    end
    lat = t + j + 1;
  endfunction

  vec_t        vt[13];
  int          lat;
  bit          err, own, oth, got, issued;
  int          exp_lat;
  bit          exp_err;
  logic [31:0] mr_a, mr_b;

  initial begin
    vt[0]  = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0,  0, 1,  32'h0,         8,  0, 32'h0,         32'h0};
    vt[1]  = '{1, 0, 32'h0000_0020, 32'h0,         6,  0, 1,  32'h1234_5678, 12, 0, 32'h0,         32'h1234_5678};
    vt[2]  = '{0, 0, 32'h0000_0044, 32'h0,         0,  0, 1,  32'hCAFE_F00D, 9,  0, 32'hCAFE_F00D, 32'h1234_5678};
    vt[3]  = '{1, 1, 32'h0000_0080, 32'h1111_2222, 2,  0, 1,  32'h0,         8,  0, 32'hCAFE_F00D, 32'h1234_5678};
    vt[4]  = '{0, 1, 32'h0000_0084, 32'h3333_4444, 5,  0, 1,  32'h0,         10, 0, 32'hCAFE_F00D, 32'h1234_5678};
    vt[5]  = '{1, 0, 32'h0000_0088, 32'h0,         0,  0, 3,  32'hA5A5_0001, 11, 0, 32'hCAFE_F00D, 32'hA5A5_0001};
    vt[6]  = '{0, 1, 32'h0000_008c, 32'h5555_6666, 0,  1, 1,  32'h0,         24, 1, 32'hCAFE_F00D, 32'hA5A5_0001};
    vt[7]  = '{1, 0, 32'h0000_0090, 32'h0,         0,  0, 0,  32'hFFFF_FFFF, 28, 1, 32'hCAFE_F00D, 32'hA5A5_0001};
    vt[8]  = '{0, 0, 32'h0000_0094, 32'h0,         0,  0, 20, 32'h5555_AAAA, 28, 0, 32'h5555_AAAA, 32'hA5A5_0001};
    vt[9]  = '{1, 1, 32'h0000_0098, 32'h7777_8888, 19, 0, 1,  32'h0,         24, 0, 32'h5555_AAAA, 32'hA5A5_0001};
    vt[10] = '{0, 1, 32'h0000_009c, 32'h9999_AAAA, 20, 0, 1,  32'h0,         24, 1, 32'h5555_AAAA, 32'hA5A5_0001};
    vt[11] = '{1, 0, 32'h0000_00a0, 32'h0,         0,  0, 21, 32'hDEAD_0001, 28, 1, 32'h5555_AAAA, 32'hA5A5_0001};
    vt[12] = '{0, 0, 32'h0000_00a4, 32'h0,         19, 0, 1,  32'h600D_CAFE, 25, 0, 32'h600D_CAFE, 32'hA5A5_0001};

    reset = 1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    lb_rd_d = 0; lb_rd_rdy = 0; hr_busy = 0; clear_timeout = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 0;

    // Both ports requesting continuously: grants alternate, A first.
    begin
      int idx = 0;
      int cyc = 0;
      int last_ack = 0;
      a_req = 1; a_we = 1; a_addr = 32'h100; a_wdata = 32'hAAAA_0000;
      b_req = 1; b_we = 1; b_addr = 32'h200; b_wdata = 32'hBBBB_0000;
      while (idx < 4 && cyc < 200) begin
        step();
        cyc++;
        if (a_ack || b_ack) begin
          chk($sformatf("arb%0d.port", idx), b_ack, 32'(idx % 2));
          chk($sformatf("arb%0d.owner", idx), owner, 32'(idx % 2));
          chk($sformatf("arb%0d.single_ack", idx), a_ack && b_ack, 0);
          chk($sformatf("arb%0d.gap", idx), cyc - last_ack, (idx == 0) ? 8 : 9);
          last_ack = cyc;
          idx++;
          if (idx == 4) begin a_req = 0; b_req = 0; end
        end
      end
      a_req = 0; b_req = 0;
      chk("arb.count", idx, 4);
      step();
    end

    for (int i = 0; i < 13; i++) begin
      busy_n = vt[i].busy_n; busy_stuck = vt[i].stuck;
      rdy_delay = vt[i].rdy_d; rdy_val = vt[i].rdy_v;
      do_txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, lat, err, own, oth, got);
      busy_stuck = 0;
      check_txn($sformatf("vec%0d", i), vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata,
                !vt[i].we, vt[i].lat, vt[i].err, vt[i].ra, vt[i].rb, lat, err, own, oth, got);
    end

    // Reset asserted between clock edges during WAIT_BUSY of an A write.
    begin
      bit seen = 0;
      busy_n = 0; busy_stuck = 1; busy_ctr = 0; rdy_ctr = 0;
      a_req = 1; a_we = 1; a_addr = 32'h300; a_wdata = 32'h1357_9BDF;
      for (int i = 0; i < 6; i++) step();
      #3 reset = 1;
      #1;
      check_reset_outputs("rst_mid");
      a_req = 0; busy_stuck = 0; hr_busy = 0;
      @(posedge clk);
      #1 reset = 0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (a_ack || b_ack) seen = 1;
      end
      chk("rst_mid.no_ack", seen, 0);
      rdy_delay = 1; rdy_val = 32'h0F0F_1234;
      do_txn(0, 0, 32'h304, 32'h0, lat, err, own, oth, got);
      check_txn("rst_read", 0, 0, 32'h304, 32'h0, 1, 9, 0, 32'h0F0F_1234, 32'h0,
                lat, err, own, oth, got);
    end

    // Stray lb_rd_rdy during SET_ADDR of a read must not land in rdata.
    glitch = 1; rdy_delay = 1; rdy_val = 32'h7654_3210;
    do_txn(0, 0, 32'h308, 32'h0, lat, err, own, oth, got);
    glitch = 0;
    check_txn("glitch", 0, 0, 32'h308, 32'h0, 1, 9, 0, 32'h7654_3210, 32'h0,
              lat, err, own, oth, got);

    mr_a = 32'h7654_3210;
    mr_b = 32'h0;
    for (int i = 0; i < 40; i++) begin
      bit          p, w;
      logic [31:0] ad, wd;
      p  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      ad = $urandom;
      wd = $urandom;
      busy_n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 24)) : int'($urandom_range(0, 6));
      rdy_delay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(17, 24)) : int'($urandom_range(1, 4));
      rdy_val   = $urandom;
      busy_stuck = 0;
      ref_model(w, busy_n, rdy_delay, exp_lat, exp_err, issued);
      if (!w && !exp_err) begin
        if (p) mr_b = rdy_val;
        else   mr_a = rdy_val;
      end
      do_txn(p, w, ad, wd, lat, err, own, oth, got);
      check_txn($sformatf("rnd%0d", i), p, w, ad, wd, issued, exp_lat, exp_err,
                mr_a, mr_b, lat, err, own, oth, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
